note_sequencer: RTL and testbench

Programmable melody sequencer that sits directly upstream of `audio_sample` and drives its `en_i`/`freq_i` pair. It holds a small table of (frequency code, duration) entries, written through a simple write port. On start it plays the entries in order: one single-cycle enable pulse per note, then holds that note for its duration in tempo ticks. It ends with a silence command. Clocked at 12.5 MHz in the synth top.

---
 rtl/note_sequencer_if.sv | 32 +++
 rtl/note_sequencer.sv | 161 ++++++++++++++++
 tb/tb_note_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Bus bundle for note_sequencer: table write port, start/stop control and
// the en/freq/done/busy outputs towards audio_sample and the host.
interface note_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int DUR_W = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en_i;
    logic [AW-1:0]    wr_addr_i;
    logic [15:0]      wr_freq_i;
    logic [DUR_W-1:0] wr_dur_i;
    logic             wr_last_i;
    logic             start_i;
    logic             stop_i;
    logic             busy_o;
    logic             en_o;
    logic [15:0]      freq_o;
    logic             done_o;

    // Host / controller side
    modport master (
        output wr_en_i, wr_addr_i, wr_freq_i, wr_dur_i, wr_last_i, start_i, stop_i,
        input  busy_o, en_o, freq_o, done_o
    );

    // Sequencer side
    modport slave (
        input  wr_en_i, wr_addr_i, wr_freq_i, wr_dur_i, wr_last_i, start_i, stop_i,
        output busy_o, en_o, freq_o, done_o
    );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: plays a table of (freq, duration, last) entries as one
// en_o strobe per note, spaced max(dur,1)*TICK_DIV cycles apart, and closes
// the song with a silence strobe (freq 0).
// Optional feature macro: NOTE_SEQ_LOOP_EN adds loop_i (repeat song forever).
module note_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 195312,
    parameter int DUR_W    = 8
) (
    input  logic clk_i,
    input  logic rstn_i,
`ifdef NOTE_SEQ_LOOP_EN
    input  logic loop_i,
`endif
    note_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TICK_DIV);
    localparam int WW = 16 + DUR_W + 1;
    // First tick segment is shortened by the FETCH and FIRE cycles so that
    // strobe-to-strobe spacing is exactly max(dur,1)*TICK_DIV.
    localparam logic [TW-1:0] TICK_FIRST  = TW'(TICK_DIV - 3);
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] PTR_LAST    = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FIRE, S_HOLD} state_t;

    state_t           r_state, w_state_next;
    logic [AW-1:0]    r_ptr, w_ptr_next;
    logic [TW-1:0]    r_tick, w_tick_next;
    logic [DUR_W-1:0] r_dur, w_dur_next;
    logic             r_last, w_last_next;     // current note ends the song
    logic             r_ending, w_ending_next; // next FETCH slot is the end strobe
    logic             r_sil, w_sil_next;       // silence strobe cycle
    logic             r_done, w_done_next;
    logic [15:0]      r_freq, w_freq_next;     // held note code between strobes

    logic [WW-1:0]    r_mem [DEPTH];
    logic [WW-1:0]    r_rd_word;
    logic [15:0]      w_rd_freq;
    logic [DUR_W-1:0] w_rd_dur;
    logic             w_rd_last;
    logic             w_loop;

    assign {w_rd_freq, w_rd_dur, w_rd_last} = r_rd_word;

`ifdef NOTE_SEQ_LOOP_EN
    assign w_loop = loop_i;
`else
    assign w_loop = 1'b0;
`endif

    // Table write port; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (bus.wr_en_i)
            r_mem[bus.wr_addr_i] <= {bus.wr_freq_i, bus.wr_dur_i, bus.wr_last_i};
    end

    // Registered read: a same-cycle write returns the old word
    always_ff @(posedge clk_i) begin
        r_rd_word <= r_mem[r_ptr];
    end

    // State and counter registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_tick   <= '0;
            r_dur    <= '0;
            r_last   <= 1'b0;
            r_ending <= 1'b0;
            r_sil    <= 1'b0;
            r_done   <= 1'b0;
            r_freq   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ptr    <= w_ptr_next;
            r_tick   <= w_tick_next;
            r_dur    <= w_dur_next;
            r_last   <= w_last_next;
            r_ending <= w_ending_next;
            r_sil    <= w_sil_next;
            r_done   <= w_done_next;
            r_freq   <= w_freq_next;
        end
    end

    // Next-state logic: stop in any active state forces a silence strobe
    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_tick_next   = r_tick;
        w_dur_next    = r_dur;
        w_last_next   = r_last;
        w_ending_next = r_ending;
        w_sil_next    = 1'b0;
        w_done_next   = 1'b0;
        w_freq_next   = r_freq;

        if (r_state != S_IDLE && bus.stop_i) begin
            w_state_next  = S_IDLE;
            w_sil_next    = 1'b1;
            w_freq_next   = '0;
            w_ending_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // r_sil: still busy with the closing strobe, start ignored
                    if (bus.start_i && !bus.stop_i && !r_sil) begin
                        w_state_next  = S_FETCH;
                        w_ptr_next    = '0;
                        w_ending_next = 1'b0;
                    end
                end
                S_FETCH: begin
                    if (r_ending) begin
                        w_state_next  = S_IDLE;
                        w_sil_next    = 1'b1;
                        w_done_next   = 1'b1;
                        w_freq_next   = '0;
                        w_ending_next = 1'b0;
                    end else begin
                        w_state_next = S_FIRE;
                    end
                end
                S_FIRE: begin
                    w_state_next = S_HOLD;
                    w_freq_next  = w_rd_freq;
                    w_tick_next  = TICK_FIRST;
                    w_dur_next   = (w_rd_dur == '0) ? '0 : w_rd_dur - DUR_W'(1);
                    w_last_next  = w_rd_last || (r_ptr == PTR_LAST);
                end
                S_HOLD: begin
                    if (r_tick != '0) begin
                        w_tick_next = r_tick - TW'(1);
                    end else if (r_dur != '0) begin
                        w_dur_next  = r_dur - DUR_W'(1);
                        w_tick_next = TICK_RELOAD;
                    end else begin
                        // Expiry: the following FETCH slot keeps spacing exact
                        w_state_next = S_FETCH;
                        if (!r_last)
                            w_ptr_next = r_ptr + AW'(1);
                        else if (w_loop)
                            w_ptr_next = '0;
                        else
                            w_ending_next = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign bus.en_o   = (r_state == S_FIRE) || r_sil;
    assign bus.freq_o = (r_state == S_FIRE) ? w_rd_freq : r_freq;
    assign bus.done_o = r_done;
    assign bus.busy_o = (r_state != S_IDLE) || r_sil;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with TICK_DIV=10: expected strobes are
// queued when stimulus is driven and compared when en_o is observed.
module tb_note_sequencer;
    localparam int DEPTH = 16;
    localparam int TDIV  = 10;
    localparam int DUR_W = 8;

    logic clk;
    logic rstn;
`ifdef NOTE_SEQ_LOOP_EN
    logic loop;
`endif

    note_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

    note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TDIV), .DUR_W(DUR_W)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
`ifdef NOTE_SEQ_LOOP_EN
        .loop_i (loop),
`endif
        .bus    (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] freq;
        logic        done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_en  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [15:0] f, input logic d);
        exp_t e;
        e.cyc = c; e.freq = f; e.done = d;
        sb_q.push_back(e);
    endtask

    // Strobe monitor: pops the scoreboard on every en_o
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.en_o) begin
                exp_t e;
                $display("strobe cycle=%0d freq=%0d done=%0d", cyc, bus.freq_o, bus.done_o);
                chk("en_gap", {31'd0, prev_en}, 32'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_cyc", cyc, e.cyc);
                    chk("strobe_freq", {16'd0, bus.freq_o}, {16'd0, e.freq});
                    chk("strobe_done", {31'd0, bus.done_o}, {31'd0, e.done});
                end
            end else if (bus.done_o) begin
                chk("done_without_en", 32'd1, 32'd0);
            end
            prev_en = bus.en_o;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic write_entry(input int a, input int f, input int d, input logic l);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 4'(a);
        bus.wr_freq_i = 16'(f);
        bus.wr_dur_i  = 8'(d);
        bus.wr_last_i = l;
        @(negedge clk);
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic pulse_start(input logic with_stop);
        bus.start_i = 1'b1;
        bus.stop_i  = with_stop;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop_i = 1'b1;
        @(negedge clk);
        bus.stop_i = 1'b0;
    endtask

    task automatic end_test(input string name, input int settle);
        repeat (settle) @(negedge clk);
        $display("test %s done", name);
        chk({name, "_sb_empty"}, sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    task automatic load_song();
        write_entry(0, 1849, 2, 1'b0);
        write_entry(1, 2197, 1, 1'b1);
    endtask

    initial begin
        int base;
        rstn          = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_freq_i = '0;
        bus.wr_dur_i  = '0;
        bus.wr_last_i = 1'b0;
        bus.start_i   = 1'b0;
        bus.stop_i    = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
        loop          = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_en",   {31'd0, bus.en_o},   32'd0);
        chk("rst_done", {31'd0, bus.done_o}, 32'd0);
        chk("rst_freq", {16'd0, bus.freq_o}, 32'd0);

        // Basic song, with an ignored start while busy at +5
        load_song();
        base = cyc;
        push(base + 2, 1849, 1'b0);
        push(base + 22, 2197, 1'b0);
        push(base + 32, 0, 1'b1);
        pulse_start(1'b0);
        chk("t1_busy_n1", {31'd0, bus.busy_o}, 32'd1);
        wait_until(base + 5);
        pulse_start(1'b0);
        wait_until(base + 32);
        chk("t1_busy_end", {31'd0, bus.busy_o}, 32'd1);
        wait_until(base + 33);
        chk("t1_busy_off", {31'd0, bus.busy_o}, 32'd0);
        end_test("t1", 15);

        // Stop mid-note
        base = cyc;
        push(base + 2, 1849, 1'b0);
        push(base + 11, 0, 1'b0);
        pulse_start(1'b0);
        wait_until(base + 10);
        pulse_stop();
        chk("t2_busy_sil", {31'd0, bus.busy_o}, 32'd1);
        wait_until(base + 12);
        chk("t2_busy_off", {31'd0, bus.busy_o}, 32'd0);
        end_test("t2", 40);

        // Rewrite entry 1 while playing, before its fetch
        base = cyc;
        push(base + 2, 1849, 1'b0);
        push(base + 22, 2468, 1'b0);
        push(base + 32, 0, 1'b1);
        pulse_start(1'b0);
        wait_until(base + 15);
        write_entry(1, 2468, 1, 1'b1);
        end_test("t5", 30);

        // Asynchronous reset mid-song
        base = cyc;
        push(base + 2, 1849, 1'b0);
        pulse_start(1'b0);
        wait_until(base + 12);
        #2;
        rstn = 1'b0;
        #1;
        chk("t7_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("t7_en",   {31'd0, bus.en_o},   32'd0);
        chk("t7_freq", {16'd0, bus.freq_o}, 32'd0);
        chk("t7_done", {31'd0, bus.done_o}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        end_test("t7", 30);

        // start and stop together in IDLE: nothing happens
        pulse_start(1'b1);
        chk("t6_busy_n1", {31'd0, bus.busy_o}, 32'd0);
        @(negedge clk);
        chk("t6_busy_n2", {31'd0, bus.busy_o}, 32'd0);
        end_test("t6", 20);

        // Duration 0 behaves as 1
        write_entry(0, 1000, 0, 1'b0);
        write_entry(1, 1100, 1, 1'b1);
        base = cyc;
        push(base + 2, 1000, 1'b0);
        push(base + 12, 1100, 1'b0);
        push(base + 22, 0, 1'b1);
        pulse_start(1'b0);
        end_test("t3", 40);

        // All entries without a last flag: ends after entry 15
        for (int k = 0; k < DEPTH; k++) write_entry(k, 100 * k + 5, 0, 1'b0);
        base = cyc;
        for (int k = 0; k < DEPTH; k++) push(base + 2 + TDIV * k, 16'(100 * k + 5), 1'b0);
        push(base + 2 + TDIV * DEPTH, 0, 1'b1);
        pulse_start(1'b0);
        wait_until(base + 3 + TDIV * DEPTH);
        chk("t4_busy_off", {31'd0, bus.busy_o}, 32'd0);
        end_test("t4", 20);

`ifdef NOTE_SEQ_LOOP_EN
        // Looping song ended only by stop
        load_song();
        loop = 1'b1;
        base = cyc;
        push(base + 2, 1849, 1'b0);
        push(base + 22, 2197, 1'b0);
        push(base + 32, 1849, 1'b0);
        push(base + 52, 2197, 1'b0);
        push(base + 56, 0, 1'b0);
        pulse_start(1'b0);
        wait_until(base + 55);
        pulse_stop();
        @(negedge clk);
        chk("loop_busy_off", {31'd0, bus.busy_o}, 32'd0);
        loop = 1'b0;
        end_test("loop", 40);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
